data_sram_responder: RTL and testbench

//  Responder end of the CPU data SRAM interface (en/we/addr/wdata -> rdata). Serves

---
 rtl/data_sram_responder.sv | 142 ++++++++++++++
 tb/tb_data_sram_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Responder for the CPU data SRAM port: word RAM plus a small MMIO window
// (LED, switch, timer, scratch, compare/irq), single-cycle registered read data.
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000,
    parameter logic [15:0] LED_RST   = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic        timer_irq
);
    localparam logic [13:0] OFF_LED     = 14'h0;
    localparam logic [13:0] OFF_SWITCH  = 14'h1;
    localparam logic [13:0] OFF_TIMER   = 14'h2;
    localparam logic [13:0] OFF_SCRATCH = 14'h3;
    localparam logic [13:0] OFF_CMP     = 14'h4;
    localparam logic [13:0] OFF_STATUS  = 14'h5;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]       ram_q [0:(1 << RAM_AW) - 1];
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_hit;
    logic [13:0]       mmio_off;
    logic              acc_wr;
    logic              ram_wr;
    logic              wr_led, wr_timer, wr_scratch, wr_cmp, wr_status;
    logic              irq_clr;
    logic [31:0]       mmio_rdata;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              irq_q, irq_d;
    logic [7:0]        sw_meta_q, sw_sync_q;
    logic              unused_ok;

    assign unused_ok = &{1'b0, data_sram_addr[1:0]};

    // Upper RAM address bits simply alias; nothing outside the MMIO window faults.
    assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign mmio_off = data_sram_addr[15:2];
    assign ram_idx  = data_sram_addr[RAM_AW+1:2];

    assign acc_wr     = data_sram_en && (data_sram_we != 4'h0);
    assign ram_wr     = acc_wr && !mmio_hit;
    assign wr_led     = acc_wr && mmio_hit && (mmio_off == OFF_LED);
    assign wr_timer   = acc_wr && mmio_hit && (mmio_off == OFF_TIMER);
    assign wr_scratch = acc_wr && mmio_hit && (mmio_off == OFF_SCRATCH);
    assign wr_cmp     = acc_wr && mmio_hit && (mmio_off == OFF_CMP);
    assign wr_status  = acc_wr && mmio_hit && (mmio_off == OFF_STATUS);
    assign irq_clr    = wr_status && data_sram_we[0] && data_sram_wdata[0];

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_LED:     mmio_rdata = {16'h0, led_q};
            OFF_SWITCH:  mmio_rdata = {24'h0, sw_sync_q};
            OFF_TIMER:   mmio_rdata = timer_q;
            OFF_SCRATCH: mmio_rdata = scratch_q;
            OFF_CMP:     mmio_rdata = cmp_q;
            OFF_STATUS:  mmio_rdata = {31'h0, irq_q};
            default:     mmio_rdata = 32'h0;
        endcase
    end

    // Read data is taken from current state, so a write returns the pre-write contents.
    always_comb begin
        rdata_d = rdata_q;
        if (data_sram_en) begin
            rdata_d = mmio_hit ? mmio_rdata : ram_q[ram_idx];
        end
    end

    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        cmp_d     = cmp_q;
        timer_d   = timer_q + 32'd1;
        irq_d     = irq_q;
        if (wr_led)     led_d     = 16'(byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_we));
        if (wr_scratch) scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
        if (wr_cmp)     cmp_d     = byte_merge(cmp_q, data_sram_wdata, data_sram_we);
        if (wr_timer)   timer_d   = byte_merge(timer_q, data_sram_wdata, data_sram_we);
        // A match on the same edge as a W1C keeps the flag set.
        if (timer_q == cmp_q) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'h0;
            led_q     <= LED_RST;
            timer_q   <= 32'h0;
            scratch_q <= 32'h0;
            cmp_q     <= 32'hffff_ffff;
            irq_q     <= 1'b0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            cmp_q     <= cmp_d;
            irq_q     <= irq_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM keeps its contents across reset; writes are simply blocked while reset is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (resetn && ram_wr) begin
            ram_q[ram_idx] <= byte_merge(ram_q[ram_idx], data_sram_wdata, data_sram_we);
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign timer_irq       = irq_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed plus randomized bench for data_sram_responder against a transaction-level model.
module tb_data_sram_responder;
    localparam int          RAM_AW    = 12;
    localparam int          RAM_WORDS = 1 << RAM_AW;
    localparam logic [15:0] MB_HI     = 16'hbfaf;
    localparam logic [15:0] LED_INIT  = 16'h5A3C;
    localparam logic [31:0] MMIO      = {MB_HI, 16'h0000};
    localparam int          POOL_IDX  = 12'h200;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    data_sram_responder #(
        .RAM_AW(RAM_AW), .MMIO_BASE(MMIO), .LED_RST(LED_INIT)
    ) dut (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .led(led), .switch(switch), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: timer is tracked as (load value, edge count at load).
    int          cyc = 0;
    int          t_cyc = 0;
    int          rst_cyc = 0;
    logic [31:0] t_base;
    logic [31:0] m_scratch, m_cmp, m_rdata;
    logic [15:0] m_led;
    logic        m_irq;
    bit          m_rd_known;
    logic [31:0] m_ram [int];
    logic [7:0]  sw_at [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_timer();
        return t_base + 32'(cyc - t_cyc);
    endfunction

    function automatic logic [7:0] m_switch(input int c);
        if (c - 2 < rst_cyc) return 8'h0;
        return sw_at[c-2];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] m;
        m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic model_reset();
        m_rdata    = 32'h0;
        m_rd_known = 1'b1;
        m_led      = LED_INIT;
        m_scratch  = 32'h0;
        m_cmp      = 32'hffff_ffff;
        m_irq      = 1'b0;
        t_base     = 32'h0;
        t_cyc      = cyc;
        rst_cyc    = cyc;
    endtask

    // One clock: drive at negedge, advance the model for the edge, check just after it.
    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] cur, rd, old;
        logic        hit, clr;
        int          idx;
        @(negedge clk);
        en = e; we = w; addr = a; wdata = d;
        sw_at[cyc] = switch;
        cur = m_timer();
        hit = (cur == m_cmp);
        clr = 1'b0;
        rd  = m_rdata;
        if (e) begin
            m_rd_known = 1'b1;
            if (a[31:16] == MB_HI) begin
                case (a[15:2])
                    14'd0:   rd = {16'h0, m_led};
                    14'd1:   rd = {24'h0, m_switch(cyc)};
                    14'd2:   rd = cur;
                    14'd3:   rd = m_scratch;
                    14'd4:   rd = m_cmp;
                    14'd5:   rd = {31'h0, m_irq};
                    default: rd = 32'h0;
                endcase
                if (w != 4'h0) begin
                    case (a[15:2])
                        14'd0: m_led = 16'(merge({16'h0, m_led}, d, w));
                        14'd2: begin t_base = merge(cur, d, w); t_cyc = cyc + 1; end
                        14'd3: m_scratch = merge(m_scratch, d, w);
                        14'd4: m_cmp = merge(m_cmp, d, w);
                        14'd5: clr = w[0] & d[0];
                        default: ;
                    endcase
                end
            end else begin
                idx = int'((a >> 2) % RAM_WORDS);
                old = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                if (!m_ram.exists(idx)) m_rd_known = 1'b0;
                rd = old;
                if (w != 4'h0) m_ram[idx] = merge(old, d, w);
            end
        end
        if (hit) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
        m_rdata = rd;
        cyc++;
        @(posedge clk);
        #1;
        if (m_rd_known) chk("rdata", rdata, m_rdata);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("irq", {31'h0, timer_irq}, {31'h0, m_irq});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        step(1'b1, w, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  w;
        int unsigned kind;
        resetn = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; switch = 8'h00;
        #2 resetn = 1'b0;
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {16'h0, led}, {16'h0, LED_INIT});
        chk("reset_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();

        // RAM word, byte lanes, read-before-write, alias
        wr(32'h100, 32'h12345678, 4'hf);
        rd(32'h100);
        chk("ram_word", rdata, 32'h12345678);
        wr(32'h100, 32'hAABBCCDD, 4'b0101);
        chk("lane_wr_old", rdata, 32'h12345678);
        rd(32'h100);
        chk("byte_lanes", rdata, 32'h12BB56DD);
        wr(32'h104, 32'h1, 4'hf);
        wr(32'h104, 32'hDEADBEEF, 4'hf);
        chk("rbw", rdata, 32'h1);
        rd(32'h104);
        chk("rd_after_wr", rdata, 32'hDEADBEEF);
        rd(32'h0000_4102);
        chk("alias", rdata, 32'h12BB56DD);
        idle();
        chk("rdata_hold", rdata, 32'h12BB56DD);

        // Timer wrap
        wr(MMIO + 32'h8, 32'hFFFF_FFFE, 4'hf);
        rd(MMIO + 32'h8);
        chk("timer_load", rdata, 32'hFFFF_FFFE);
        idle();
        rd(MMIO + 32'h8);
        chk("timer_wrap", rdata, 32'h0);

        // IRQ set, W1C, CMP timing, set-wins
        wr(MMIO + 32'h10, 32'h20, 4'hf);
        wr(MMIO + 32'h14, 32'h1, 4'h1);
        chk("w1c_first", {31'h0, timer_irq}, 32'h0);
        wr(MMIO + 32'h8, 32'h1E, 4'hf);
        idle();
        chk("irq_e1", {31'h0, timer_irq}, 32'h0);
        idle();
        chk("irq_e2", {31'h0, timer_irq}, 32'h0);
        idle();
        chk("irq_rise", {31'h0, timer_irq}, 32'h1);
        wr(MMIO + 32'h14, 32'h1, 4'hf);
        chk("w1c", {31'h0, timer_irq}, 32'h0);
        wr(MMIO + 32'h8, 32'h1E, 4'hf);
        idle();
        idle();
        wr(MMIO + 32'h14, 32'h1, 4'hf);
        chk("w1c_vs_set", {31'h0, timer_irq}, 32'h1);
        rd(MMIO + 32'h14);
        chk("status_rd", rdata, 32'h1);
        wr(MMIO + 32'h14, 32'h1, 4'hf);
        wr(MMIO + 32'h10, m_timer(), 4'hf);
        idle();
        chk("cmp_next_cycle", {31'h0, timer_irq}, 32'h0);

        // LED, scratch, undefined offsets
        wr(MMIO, 32'hFFFF_1234, 4'hf);
        chk("led_wr", {16'h0, led}, 32'h1234);
        wr(MMIO, 32'h0000_AB00, 4'b0010);
        rd(MMIO);
        chk("led_rd", rdata, 32'h0000_AB34);
        wr(MMIO + 32'hC, 32'hCAFE_F00D, 4'hf);
        rd(MMIO + 32'hC);
        chk("scratch", rdata, 32'hCAFE_F00D);
        wr(MMIO + 32'h18, 32'hFFFF_FFFF, 4'hf);
        rd(MMIO + 32'h18);
        chk("undef_off", rdata, 32'h0);
        switch = 8'hA5;
        idle();
        idle();
        rd(MMIO + 32'h4);
        chk("switch", rdata, 32'hA5);

        // Randomized traffic
        for (int i = 0; i < 8; i++) wr(32'(POOL_IDX + i) << 2, $urandom, 4'hf);
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 5) == 0) switch = 8'($urandom);
            d = $urandom;
            w = 4'($urandom);
            if (kind == 0) begin
                step(1'b0, w, d, d);
            end else if (kind <= 4) begin
                a = $urandom;
                a[13:2] = 12'(POOL_IDX + int'($urandom_range(0, 7)));
                if (a[31:16] == MB_HI) a[31] = ~a[31];
                if ($urandom_range(0, 1) == 0) w = 4'h0;
                step(1'b1, w, a, d);
            end else if (kind <= 8) begin
                a = {MB_HI, 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3))};
                if ($urandom_range(0, 9) == 0) a[15:0] = 16'h0100;
                if ($urandom_range(0, 1) == 0) w = 4'h0;
                step(1'b1, w, a, d);
            end else begin
                step(1'b1, 4'hf, MMIO + 32'h10, m_timer() + 32'($urandom_range(1, 6)));
            end
        end

        // Reset in the middle of a read, with a write held during reset
        wr(MMIO, 32'h0000_BEEF, 4'hf);
        wr(MMIO + 32'h10, 32'h40, 4'hf);
        wr(MMIO + 32'h8, 32'h3F, 4'hf);
        idle();
        idle();
        chk("irq_pre_reset", {31'h0, timer_irq}, 32'h1);
        switch = 8'hC3;
        rd(32'h100);
        chk("rd_pre_reset", rdata, 32'h12BB56DD);
        @(negedge clk);
        en = 1'b1; we = 4'h0; addr = 32'h104;
        #2 resetn = 1'b0;
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", {16'h0, led}, {16'h0, LED_INIT});
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        we = 4'hf; wdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1 chk("rst_hold", rdata, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        en = 1'b0; we = 4'h0;
        model_reset();
        rd(MMIO + 32'h4);
        chk("sw_sync_reset", rdata, 32'h0);
        rd(MMIO + 32'h8);
        chk("timer_after_reset", rdata, 32'h1);
        rd(32'h104);
        chk("wr_lost", rdata, 32'hDEADBEEF);
        rd(MMIO + 32'h10);
        chk("cmp_reset", rdata, 32'hFFFF_FFFF);
        rd(MMIO + 32'hC);
        chk("scratch_reset", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
